// File: rtl/dctlb_pkg.sv
// rtl/dctlb_pkg.sv - shared DCTLB types, defaults and slot helpers
package dctlb_pkg;

   localparam int LADDR_W        = 39;
   localparam int PF_DEPTH_DEF   = 4;
   localparam int STARVE_MAX_DEF = 16;

   typedef struct packed {
      logic [LADDR_W-1:0] laddr;
      logic               l2;
   } I_pfetol1tlb_req_type;

   typedef enum logic {
      SLOT_LD = 1'b0,
      SLOT_ST = 1'b1
   } slot_e;

   // Home slot of a request: l2 requests can only travel on the st slot.
   function automatic slot_e slot_of(input I_pfetol1tlb_req_type r);
      return r.l2 ? SLOT_ST : SLOT_LD;
   endfunction

endpackage

// File: rtl/dctlb_pf_sched_if.sv
// rtl/dctlb_pf_sched_if.sv - prefetch scheduler request, core slot and fwd slot signals
interface dctlb_pf_sched_if
   import dctlb_pkg::*;
#(
   parameter int DROP_W = 8
) ();

   logic                 pfetol1tlb_req_valid;
   logic                 pfetol1tlb_req_retry;
   I_pfetol1tlb_req_type pfetol1tlb_req;
   logic                 coretodctlb_ld_valid;
   logic                 coretodctlb_st_valid;
   logic                 sched_ld_stall;
   logic                 sched_st_stall;
   logic                 sched_pf0_valid;
   logic                 sched_pf0_retry;
   I_pfetol1tlb_req_type sched_pf0;
   logic                 sched_pf1_valid;
   logic                 sched_pf1_retry;
   I_pfetol1tlb_req_type sched_pf1;
   logic [DROP_W-1:0]    drop_count;

   modport master (
      output pfetol1tlb_req_valid, pfetol1tlb_req,
      output coretodctlb_ld_valid, coretodctlb_st_valid,
      output sched_pf0_retry, sched_pf1_retry,
      input  pfetol1tlb_req_retry, sched_ld_stall, sched_st_stall,
      input  sched_pf0_valid, sched_pf0, sched_pf1_valid, sched_pf1,
      input  drop_count
   );

   modport slave (
      input  pfetol1tlb_req_valid, pfetol1tlb_req,
      input  coretodctlb_ld_valid, coretodctlb_st_valid,
      input  sched_pf0_retry, sched_pf1_retry,
      output pfetol1tlb_req_retry, sched_ld_stall, sched_st_stall,
      output sched_pf0_valid, sched_pf0, sched_pf1_valid, sched_pf1,
      output drop_count
   );

endinterface

// File: rtl/dctlb_pf_fifo.sv
// rtl/dctlb_pf_fifo.sv - drop-oldest circular prefetch FIFO with head/head+1 view
module dctlb_pf_fifo
   import dctlb_pkg::*;
#(
   parameter int DEPTH = PF_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  I_pfetol1tlb_req_type   push_data,
   input  logic                   pop1,
   input  logic                   pop2,
   output I_pfetol1tlb_req_type   head,
   output I_pfetol1tlb_req_type   head1,
   output logic [$clog2(DEPTH):0] count,
   output logic                   drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   I_pfetol1tlb_req_type mem [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [1:0]           pop_n;
   logic                 full;

   // Number of entries leaving from the head this cycle.
   always_comb begin
      pop_n = 2'd0;
      if (pop2)
         pop_n = 2'd2;
      else if (pop1)
         pop_n = 2'd1;
   end

   // A push into a full FIFO with nothing leaving evicts the oldest entry.
   assign full  = (count == CW'(DEPTH));
   assign drop  = push & full & ~(pop1 | pop2);
   assign head  = mem[rd_ptr];
   assign head1 = mem[rd_ptr + AW'(1)];

   // Entry storage; payload needs no reset because count gates its use.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy update; an eviction advances rd_ptr like a pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr + AW'(pop_n) + AW'(drop);
         count  <= count + CW'(push) - CW'(pop_n) - CW'(drop);
      end
   end

endmodule

// File: rtl/dctlb_pf_sched.sv
// rtl/dctlb_pf_sched.sv - injects buffered prefetches into idle DCTLB ld/st fwd slots
module dctlb_pf_sched
   import dctlb_pkg::*;
#(
   parameter int PF_DEPTH   = PF_DEPTH_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int DROP_W     = 8
) (
   input logic             clk,
   input logic             reset,
   dctlb_pf_sched_if.slave bus
);

   localparam int CW = $clog2(PF_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   I_pfetol1tlb_req_type head;
   I_pfetol1tlb_req_type head1;
   I_pfetol1tlb_req_type pend0_data;
   I_pfetol1tlb_req_type pend1_data;
   I_pfetol1tlb_req_type pf0_data;
   I_pfetol1tlb_req_type pf1_data;
   logic [CW-1:0]        count;
   logic [SW-1:0]        starve_cnt;
   logic [DROP_W-1:0]    drop_cnt;
   logic                 fifo_drop;
   logic                 pop1;
   logic                 pop2;
   logic                 pend0;
   logic                 pend1;
   logic                 has1;
   logic                 has2;
   logic                 starved;
   logic                 force0;
   logic                 force1;
   logic                 avail0;
   logic                 avail1;
   logic                 new0;
   logic                 new1;
   logic                 new1_h1;
   logic                 pf0_valid;
   logic                 pf1_valid;
   logic                 xfer0;
   logic                 xfer1;

   dctlb_pf_fifo #(
      .DEPTH (PF_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.pfetol1tlb_req_valid),
      .push_data (bus.pfetol1tlb_req),
      .pop1      (pop1),
      .pop2      (pop2),
      .head      (head),
      .head1     (head1),
      .count     (count),
      .drop      (fifo_drop)
   );

   // Slot selection: head first into its preferred free slot, head+1 rides slot 1
   // only when the head took slot 0. A forced slot ignores the core valid but never
   // overrides an entry already pending there. An entry leaves the FIFO once it is
   // committed to a slot; a retried entry is then held in that slot's pending register.
   always_comb begin
      has1    = (count != '0);
      has2    = (count > CW'(1));
      starved = has1 && (starve_cnt == SW'(STARVE_MAX));
      force0  = starved && (slot_of(head) == SLOT_LD);
      force1  = starved && (slot_of(head) == SLOT_ST);
      avail0  = ~pend0 & (~bus.coretodctlb_ld_valid | force0);
      avail1  = ~pend1 & (~bus.coretodctlb_st_valid | force1);
      new0    = 1'b0;
      new1    = 1'b0;
      new1_h1 = 1'b0;
      if (has1) begin
         if ((slot_of(head) == SLOT_LD) && avail0) begin
            new0 = 1'b1;
            if (has2 && avail1) begin
               new1    = 1'b1;
               new1_h1 = 1'b1;
            end
         end else if (avail1) begin
            new1 = 1'b1;
         end
      end
      pf0_valid = pend0 | new0;
      pf1_valid = pend1 | new1;
      pf0_data  = pend0 ? pend0_data : head;
      pf1_data  = pend1 ? pend1_data : (new1_h1 ? head1 : head);
      xfer0     = pf0_valid & ~bus.sched_pf0_retry;
      xfer1     = pf1_valid & ~bus.sched_pf1_retry;
      pop1      = new0 ^ new1;
      pop2      = new0 & new1;
   end

   assign bus.pfetol1tlb_req_retry = 1'b0;
   assign bus.sched_pf0_valid      = pf0_valid;
   assign bus.sched_pf1_valid      = pf1_valid;
   assign bus.sched_pf0            = pf0_data;
   assign bus.sched_pf1            = pf1_data;
   assign bus.sched_ld_stall       = pend0 | force0;
   assign bus.sched_st_stall       = pend1 | force1;
   assign bus.drop_count           = drop_cnt;

   // Pending flags: a slot stays pending for as long as its presentation is retried.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend0 <= 1'b0;
         pend1 <= 1'b0;
      end else begin
         pend0 <= pf0_valid & bus.sched_pf0_retry;
         pend1 <= pf1_valid & bus.sched_pf1_retry;
      end
   end

   // Pending payload capture; re-presenting a pending entry rewrites the same value.
   always_ff @(posedge clk) begin
      if (pf0_valid & bus.sched_pf0_retry)
         pend0_data <= pf0_data;
      if (pf1_valid & bus.sched_pf1_retry)
         pend1_data <= pf1_data;
   end

   // Starvation counter: counts non-empty cycles without a transfer, saturates at the limit.
   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (!has1 || xfer0 || xfer1)
         starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
         starve_cnt <= starve_cnt + SW'(1);
   end

   // Saturating count of prefetches evicted on overflow.
   always_ff @(posedge clk) begin
      if (reset)
         drop_cnt <= '0;
      else if (fifo_drop && (drop_cnt != '1))
         drop_cnt <= drop_cnt + DROP_W'(1);
   end

endmodule

// File: tb/tb_dctlb_pf_sched.sv
// tb/tb_dctlb_pf_sched.sv - directed scoreboard bench for dctlb_pf_sched
module tb_dctlb_pf_sched;
   import dctlb_pkg::*;

   localparam int PF_DEPTH = 4;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_drops = 0;
   I_pfetol1tlb_req_type exp_q [$];

   dctlb_pf_sched_if #(.DROP_W(8)) bus ();

   dctlb_pf_sched #(
      .PF_DEPTH   (PF_DEPTH),
      .STARVE_MAX (16),
      .DROP_W     (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic I_pfetol1tlb_req_type mk(input int a, input bit l2);
      I_pfetol1tlb_req_type r;
      r.laddr = LADDR_W'(a);
      r.l2    = l2;
      return r;
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // blocked=1 means the core holds both slots this cycle, so a full FIFO evicts its oldest
   task automatic drive_push(input I_pfetol1tlb_req_type r, input bit blocked);
      I_pfetol1tlb_req_type tmp;
      bus.pfetol1tlb_req_valid = 1'b1;
      bus.pfetol1tlb_req       = r;
      if (blocked && exp_q.size() >= PF_DEPTH) begin
         tmp = exp_q.pop_front();
         exp_drops++;
      end
      exp_q.push_back(r);
   endtask

   // scoreboard: every transfer must match the oldest outstanding expected request
   always @(negedge clk) begin
      I_pfetol1tlb_req_type e;
      if (!reset) begin
         if (bus.sched_pf0_valid && !bus.sched_pf0_retry) begin
            chk("sb_pf0_l2", 64'(bus.sched_pf0.l2), 64'(0));
            chk("sb_pf0_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_pf0_data", 64'(bus.sched_pf0), 64'(e));
            end
         end
         if (bus.sched_pf1_valid && !bus.sched_pf1_retry) begin
            chk("sb_pf1_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_pf1_data", 64'(bus.sched_pf1), 64'(e));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.pfetol1tlb_req_valid = 1'b0;
      bus.pfetol1tlb_req       = '0;
      bus.coretodctlb_ld_valid = 1'b0;
      bus.coretodctlb_st_valid = 1'b0;
      bus.sched_pf0_retry      = 1'b0;
      bus.sched_pf1_retry      = 1'b0;
      nxt();
      nxt();
      reset = 1'b0;

      // reset state
      smp();
      chk("rst_pf0_valid", 64'(bus.sched_pf0_valid), 64'(0));
      chk("rst_pf1_valid", 64'(bus.sched_pf1_valid), 64'(0));
      chk("rst_ld_stall", 64'(bus.sched_ld_stall), 64'(0));
      chk("rst_st_stall", 64'(bus.sched_st_stall), 64'(0));
      chk("rst_drop", 64'(bus.drop_count), 64'(0));
      chk("rst_req_retry", 64'(bus.pfetol1tlb_req_retry), 64'(0));
      nxt();

      // idle core: two buffered l2=0 entries issue together
      bus.coretodctlb_ld_valid = 1'b1;
      bus.coretodctlb_st_valid = 1'b1;
      drive_push(mk('h100, 1'b0), 1'b1);
      smp();
      nxt();
      drive_push(mk('h101, 1'b0), 1'b1);
      smp();
      chk("idle_hold_pf0", 64'(bus.sched_pf0_valid), 64'(0));
      nxt();
      bus.pfetol1tlb_req_valid = 1'b0;
      bus.coretodctlb_ld_valid = 1'b0;
      bus.coretodctlb_st_valid = 1'b0;
      smp();
      chk("idle_pf0_valid", 64'(bus.sched_pf0_valid), 64'(1));
      chk("idle_pf0_data", 64'(bus.sched_pf0), 64'(mk('h100, 1'b0)));
      chk("idle_pf1_valid", 64'(bus.sched_pf1_valid), 64'(1));
      chk("idle_pf1_data", 64'(bus.sched_pf1), 64'(mk('h101, 1'b0)));
      nxt();
      smp();
      chk("idle_empty_pf0", 64'(bus.sched_pf0_valid), 64'(0));
      chk("idle_empty_pf1", 64'(bus.sched_pf1_valid), 64'(0));
      nxt();

      // l2 routing: l2=1 waits for slot 1 even though slot 0 is idle
      bus.coretodctlb_st_valid = 1'b1;
      drive_push(mk('h200, 1'b1), 1'b0);
      smp();
      nxt();
      bus.pfetol1tlb_req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         smp();
         chk("l2_wait_pf0", 64'(bus.sched_pf0_valid), 64'(0));
         chk("l2_wait_pf1", 64'(bus.sched_pf1_valid), 64'(0));
         nxt();
      end
      bus.coretodctlb_st_valid = 1'b0;
      smp();
      chk("l2_pf1_valid", 64'(bus.sched_pf1_valid), 64'(1));
      chk("l2_pf1_data", 64'(bus.sched_pf1), 64'(mk('h200, 1'b1)));
      chk("l2_pf0_quiet", 64'(bus.sched_pf0_valid), 64'(0));
      nxt();
      smp();
      chk("l2_done_pf1", 64'(bus.sched_pf1_valid), 64'(0));
      nxt();

      // overflow: six pushes into four entries while both slots are busy
      bus.coretodctlb_ld_valid = 1'b1;
      bus.coretodctlb_st_valid = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         drive_push(mk('h300 + i, 1'b0), 1'b1);
         smp();
         chk("ovf_hold_pf0", 64'(bus.sched_pf0_valid), 64'(0));
         nxt();
      end
      // full FIFO with a pop in the same cycle: push without drop
      bus.coretodctlb_ld_valid = 1'b0;
      bus.coretodctlb_st_valid = 1'b0;
      drive_push(mk('h307, 1'b0), 1'b0);
      smp();
      chk("ovf_drop_model", 64'(bus.drop_count), 64'(exp_drops));
      chk("ovf_drop_two", 64'(bus.drop_count), 64'(2));
      chk("ovf_pf0_r3", 64'(bus.sched_pf0), 64'(mk('h303, 1'b0)));
      chk("ovf_pf1_r4", 64'(bus.sched_pf1), 64'(mk('h304, 1'b0)));
      nxt();
      bus.pfetol1tlb_req_valid = 1'b0;
      smp();
      chk("ovf_pf0_r5", 64'(bus.sched_pf0), 64'(mk('h305, 1'b0)));
      chk("ovf_pf1_r6", 64'(bus.sched_pf1), 64'(mk('h306, 1'b0)));
      chk("ovf_no_new_drop", 64'(bus.drop_count), 64'(2));
      nxt();
      smp();
      chk("ovf_pf0_r7_valid", 64'(bus.sched_pf0_valid), 64'(1));
      chk("ovf_pf0_r7", 64'(bus.sched_pf0), 64'(mk('h307, 1'b0)));
      chk("ovf_pf1_quiet", 64'(bus.sched_pf1_valid), 64'(0));
      nxt();
      smp();
      chk("ovf_empty", 64'(bus.sched_pf0_valid), 64'(0));
      nxt();

      // starvation: one l2=0 entry behind a permanently busy core
      bus.coretodctlb_ld_valid = 1'b1;
      bus.coretodctlb_st_valid = 1'b1;
      drive_push(mk('h400, 1'b0), 1'b1);
      smp();
      nxt();
      bus.pfetol1tlb_req_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         smp();
         chk("stv_pre_stall", 64'(bus.sched_ld_stall), 64'(0));
         chk("stv_pre_pf0", 64'(bus.sched_pf0_valid), 64'(0));
         nxt();
      end
      smp();
      chk("stv_ld_stall", 64'(bus.sched_ld_stall), 64'(1));
      chk("stv_pf0_valid", 64'(bus.sched_pf0_valid), 64'(1));
      chk("stv_pf0_data", 64'(bus.sched_pf0), 64'(mk('h400, 1'b0)));
      chk("stv_st_stall", 64'(bus.sched_st_stall), 64'(0));
      nxt();
      smp();
      chk("stv_post_stall", 64'(bus.sched_ld_stall), 64'(0));
      chk("stv_post_pf0", 64'(bus.sched_pf0_valid), 64'(0));
      nxt();

      // retry hold on slot 0: three retried presentations then transfer
      bus.coretodctlb_ld_valid = 1'b0;
      bus.coretodctlb_st_valid = 1'b1;
      bus.sched_pf0_retry      = 1'b1;
      drive_push(mk('h500, 1'b0), 1'b1);
      smp();
      nxt();
      bus.pfetol1tlb_req_valid = 1'b0;
      smp();
      chk("rty_c1_valid", 64'(bus.sched_pf0_valid), 64'(1));
      chk("rty_c1_data", 64'(bus.sched_pf0), 64'(mk('h500, 1'b0)));
      chk("rty_c1_stall", 64'(bus.sched_ld_stall), 64'(0));
      nxt();
      bus.coretodctlb_ld_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         smp();
         chk("rty_hold_valid", 64'(bus.sched_pf0_valid), 64'(1));
         chk("rty_hold_data", 64'(bus.sched_pf0), 64'(mk('h500, 1'b0)));
         chk("rty_hold_stall", 64'(bus.sched_ld_stall), 64'(1));
         nxt();
      end
      bus.sched_pf0_retry = 1'b0;
      smp();
      chk("rty_c4_valid", 64'(bus.sched_pf0_valid), 64'(1));
      chk("rty_c4_data", 64'(bus.sched_pf0), 64'(mk('h500, 1'b0)));
      chk("rty_c4_stall", 64'(bus.sched_ld_stall), 64'(1));
      nxt();
      smp();
      chk("rty_c5_stall", 64'(bus.sched_ld_stall), 64'(0));
      chk("rty_c5_valid", 64'(bus.sched_pf0_valid), 64'(0));
      nxt();

      // reset mid-stream with three entries buffered
      bus.coretodctlb_ld_valid = 1'b1;
      bus.coretodctlb_st_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_push(mk('h600 + i, 1'b0), 1'b1);
         smp();
         nxt();
      end
      bus.pfetol1tlb_req_valid = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      exp_drops = 0;
      smp();
      nxt();
      reset = 1'b0;
      bus.coretodctlb_ld_valid = 1'b0;
      bus.coretodctlb_st_valid = 1'b0;
      smp();
      chk("mrst_pf0_valid", 64'(bus.sched_pf0_valid), 64'(0));
      chk("mrst_pf1_valid", 64'(bus.sched_pf1_valid), 64'(0));
      chk("mrst_ld_stall", 64'(bus.sched_ld_stall), 64'(0));
      chk("mrst_st_stall", 64'(bus.sched_st_stall), 64'(0));
      chk("mrst_drop", 64'(bus.drop_count), 64'(exp_drops));
      nxt();
      smp();
      chk("mrst_empty_pf0", 64'(bus.sched_pf0_valid), 64'(0));
      chk("mrst_empty_pf1", 64'(bus.sched_pf1_valid), 64'(0));
      nxt();

      chk("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
